uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Shares one UART transmitter between N_REQ requesters using round-robin
// arbitration. Each grant launches one frame. The grant ends when the
// transmitter reports completion or when the frame timeout expires.
//
// Ports
//   clk_i          single clock, rising edge
//   reset_i        asynchronous, active-high reset
//   req_valid_i    per-requester "byte available"
//   req_data_i     per-requester byte, requester i in [8i+7:8i]
//   req_ready_o    combinational one-hot accept (IDLE only)
//   tx_start_o     one-cycle frame launch pulse
//   tx_data_o      byte presented to the transmitter
//   tx_busy_i      transmitter is shifting a frame
//   tx_done_i      transmitter finished a frame (one-cycle pulse)
//   grant_id_o     requester currently being served
//   active_o       scheduler is not idle
//   timeout_err_o  one-cycle pulse on a timeout abort
//   err_count_o    saturating count of timeout aborts
//
// State       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | arbitrating; req_ready_o offered to the round-robin winner
// S_LOAD      | tx_start_o high; timeout counter cleared
// S_WAIT_BUSY | waiting for the transmitter to pick up the frame
// S_WAIT_DONE | transmitter shifting; waiting for tx_done_i

module uart_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CNT_W          = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [8*N_REQ-1:0]       req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     tx_start_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_busy_i,
    input  logic                     tx_done_i,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     active_o,
    output logic                     timeout_err_o,
    output logic [7:0]               err_count_o
);

    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t          state_q;
    logic            tx_start_q;
    logic [7:0]      tx_data_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic            timeout_err_q;
    logic [7:0]      err_cnt_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       err_cnt_d;
    logic [GW-1:0]    winner;
    logic             found;
    logic [7:0]       win_data;
    logic             timeout_hit;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (GW'(k) == winner) begin
                win_data = req_data_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && found) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    assign cnt_d       = cnt_q + CNT_W'(1);
    // The abort fires on the edge where the counter would reach its limit.
    assign timeout_hit = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err_cnt_d   = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_q       <= '0;
            last_grant_q  <= GW'(N_REQ - 1);
            timeout_err_q <= 1'b0;
            err_cnt_q     <= 8'h00;
            cnt_q         <= '0;
        end else begin
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        tx_data_q  <= win_data;
                        grant_q    <= winner;
                        tx_start_q <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    // Completion has priority over a coincident timeout.
                    if (tx_done_i) begin
                        last_grant_q <= grant_q;
                        state_q      <= S_IDLE;
                    end else if (timeout_hit) begin
                        last_grant_q  <= grant_q;
                        timeout_err_q <= 1'b1;
                        err_cnt_q     <= err_cnt_d;
                        cnt_q         <= cnt_d;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (state_q == S_WAIT_BUSY && tx_busy_i) begin
                            state_q <= S_WAIT_DONE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_start_o    = tx_start_q;
    assign tx_data_o     = tx_data_q;
    assign grant_id_o    = grant_q;
    assign active_o      = (state_q != S_IDLE);
    assign timeout_err_o = timeout_err_q;
    assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler. Expected {grant, byte} pairs are
// queued as requests are driven and checked whenever tx_start_o fires.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int TO = 20;

    logic        clk_i;
    logic        reset_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        tx_busy_i;
    logic        tx_done_i;
    logic [1:0]  grant_id_o;
    logic        active_o;
    logic        timeout_err_o;
    logic [7:0]  err_count_o;

    int vectors     = 0;
    int miscompares = 0;
    int tx_mode     = 0;   // 0 normal, 1 fast done, 2 silent, 3 done on last allowed cycle
    logic [15:0] sb_q[$];

    uart_tx_scheduler #(
        .N_REQ(N),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .tx_start_o(tx_start_o),
        .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i),
        .tx_done_i(tx_done_i),
        .grant_id_o(grant_id_o),
        .active_o(active_o),
        .timeout_err_o(timeout_err_o),
        .err_count_o(err_count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int gid, input logic [7:0] data);
        sb_q.push_back({8'(gid), data});
    endtask

    task automatic wait_start(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (tx_start_o) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_start_seen"}, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!active_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check({tag, "_idle_seen"}, 32'(got), 32'd1);
    endtask

    task automatic send(input logic [3:0] valid, input int nstarts, input string tag);
        req_valid_i = valid;
        for (int s = 0; s < nstarts; s++) wait_start(tag);
        req_valid_i = '0;
        wait_idle(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_start"},  32'(tx_start_o),    32'd0);
        check({tag, "_tx_data"},   32'(tx_data_o),     32'h00);
        check({tag, "_grant"},     32'(grant_id_o),    32'd0);
        check({tag, "_timeout"},   32'(timeout_err_o), 32'd0);
        check({tag, "_err_count"}, 32'(err_count_o),   32'd0);
        check({tag, "_active"},    32'(active_o),      32'd0);
        check({tag, "_ready"},     32'(req_ready_o),   32'd0);
    endtask

    // Scoreboard: every launched frame must match the oldest queued expectation.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk_i);
            if (!reset_i && tx_start_o) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    check("tx_data",  32'(tx_data_o),  32'(exp[7:0]));
                    check("grant_id", 32'(grant_id_o), 32'(exp[15:8]));
                end
            end
        end
    end

    // Transmitter model.
    initial begin
        tx_busy_i = 1'b0;
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_o && !reset_i) begin
                case (tx_mode)
                    0: begin
                        @(negedge clk_i);
                        tx_busy_i = 1'b1;
                        repeat (3) @(negedge clk_i);
                        tx_busy_i = 1'b0;
                        tx_done_i = 1'b1;
                        @(negedge clk_i);
                        tx_done_i = 1'b0;
                    end
                    1: begin
                        @(negedge clk_i);
                        tx_done_i = 1'b1;
                        @(negedge clk_i);
                        tx_done_i = 1'b0;
                    end
                    3: begin
                        repeat (TO - 1) @(negedge clk_i);
                        tx_done_i = 1'b1;
                        @(negedge clk_i);
                        tx_done_i = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    initial begin
        int   k;
        logic seen;

        reset_i     = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        repeat (3) @(negedge clk_i);
        check_reset_vals("por");
        reset_i = 1'b0;
        @(negedge clk_i);

        // Single request from requester 0.
        req_data_i[7:0] = 8'h55;
        req_valid_i     = 4'b0001;
        push(0, 8'h55);
        #1;
        check("single_ready", 32'(req_ready_o), 32'b0001);
        @(negedge clk_i);
        check("single_start",      32'(tx_start_o),  32'd1);
        check("single_ready_load", 32'(req_ready_o), 32'd0);
        req_valid_i = '0;   // dropping valid after capture must not matter
        wait_idle("single");

        // Fresh reset, then all four requesters held.
        @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check_reset_vals("rst2");
        @(negedge clk_i);
        reset_i    = 1'b0;
        req_data_i = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        push(0, 8'hA0);
        push(1, 8'hA1);
        push(2, 8'hA2);
        push(3, 8'hA3);
        push(0, 8'hA0);
        send(4'b1111, 5, "rr");

        // Wrap-around and search order.
        req_data_i = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        push(3, 8'hD3);
        send(4'b1000, 1, "g3");
        push(2, 8'hD2);
        send(4'b0100, 1, "wrap2");
        push(0, 8'hD0);
        push(2, 8'hD2);
        send(4'b0101, 2, "pair");

        // Fast transmitter: tx_done_i in WAIT_BUSY.
        tx_mode = 1;
        push(3, 8'hD3);
        req_valid_i = 4'b1000;
        wait_start("fast");
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("fast_idle",    32'(active_o),      32'd0);
        check("fast_no_to",   32'(timeout_err_o), 32'd0);

        // Completion on the final allowed cycle beats the timeout.
        tx_mode = 3;
        push(0, 8'hD0);
        req_valid_i = 4'b0001;
        wait_start("late");
        req_valid_i = '0;
        seen = 1'b0;
        for (int i = 0; i < TO + 3; i++) begin
            @(negedge clk_i);
            if (timeout_err_o) seen = 1'b1;
        end
        check("late_no_to",     32'(seen),        32'd0);
        check("late_err_count", 32'(err_count_o), 32'd0);
        check("late_idle",      32'(active_o),    32'd0);

        // Silent transmitter: timeout abort.
        tx_mode = 2;
        push(1, 8'hD1);
        req_valid_i = 4'b0010;
        wait_start("to");
        req_valid_i = '0;
        k = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            @(negedge clk_i);
            if (timeout_err_o) begin
                k = i;
                break;
            end
        end
        check("to_latency",   32'(k),           32'(TO));
        check("to_err_count", 32'(err_count_o), 32'd1);
        check("to_idle",      32'(active_o),    32'd0);
        @(negedge clk_i);
        check("to_pulse_width", 32'(timeout_err_o), 32'd0);
        tx_mode = 0;
        push(2, 8'hD2);
        send(4'b0110, 1, "after_to");

        // Reset while the transmitter is shifting.
        push(3, 8'hD3);
        req_valid_i = 4'b1000;
        wait_start("mid");
        req_valid_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_active", 32'(active_o), 32'd1);
        reset_i = 1'b1;
        #1;
        check_reset_vals("mid");
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check("mid_stays_idle", 32'(active_o), 32'd0);
        push(0, 8'hD0);
        send(4'b1111, 1, "post_rst");

        repeat (2) @(negedge clk_i);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
